// File: rtl/ov7670_capture.sv
// OV7670 capture front end: frames vsync/href, pairs RGB565 bytes, writes RGB332 pixels.
// Define CAPTURE_DOWNSCALE_EN for 2x2 decimated capture (H_ACTIVE/2 x V_ACTIVE/2).

module ov7670_capture #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned ADDR_W   = 19
) (
   input  logic              ov7670_pclk,
   input  logic              reset,
   input  logic              ov7670_vsync,
   input  logic              ov7670_href,
   input  logic [7:0]        ov7670_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              frame_done,
   output logic              line_err
);

   localparam int unsigned XW = $clog2(H_ACTIVE + 2);
   localparam int unsigned YW = $clog2(V_ACTIVE + 1);
   localparam int unsigned CW = ADDR_W + 1;
`ifdef CAPTURE_DOWNSCALE_EN
   localparam int unsigned AddrLimit = (H_ACTIVE * V_ACTIVE) / 4;
`else
   localparam int unsigned AddrLimit = H_ACTIVE * V_ACTIVE;
`endif

   typedef enum logic [1:0] {StIdle, StSync, StActive} state_e;

   state_e            state_q, state_d;
   logic              vsync_q, vsync_qq, href_q, href_qq;
   logic [7:0]        data_q;
   logic              phase_q, phase_d;
   logic [5:0]        hi_q, hi_d;       // {R[4:2], G[5:3]} of the held first byte
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              frame_done_q, frame_done_d;
   logic              line_err_q, line_err_d;
   logic              vs_rise, vs_fall, href_fall;
   logic              write_ok;
   logic [CW-1:0]     pix_addr;

`ifdef CAPTURE_DOWNSCALE_EN
   assign pix_addr = CW'(y_q >> 1) * CW'(H_ACTIVE / 2) + CW'(x_q >> 1);
   assign write_ok = !x_q[0] && !y_q[0] && (x_q < XW'(H_ACTIVE)) && (y_q < YW'(V_ACTIVE)) &&
                     (pix_addr < CW'(AddrLimit));
`else
   logic [CW-1:0] addr_q, addr_d;

   assign pix_addr = addr_q;
   assign write_ok = (addr_q < CW'(AddrLimit)) && (y_q < YW'(V_ACTIVE));
`endif

   assign vs_rise   = vsync_q & ~vsync_qq;
   assign vs_fall   = ~vsync_q & vsync_qq;
   assign href_fall = ~href_q & href_qq;

   always_ff @(posedge ov7670_pclk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         vsync_q      <= 1'b0;
         vsync_qq     <= 1'b0;
         href_q       <= 1'b0;
         href_qq      <= 1'b0;
         data_q       <= '0;
         phase_q      <= 1'b0;
         hi_q         <= '0;
         x_q          <= '0;
         y_q          <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         line_err_q   <= 1'b0;
`ifndef CAPTURE_DOWNSCALE_EN
         addr_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         vsync_q      <= ov7670_vsync;
         vsync_qq     <= vsync_q;
         href_q       <= ov7670_href;
         href_qq      <= href_q;
         data_q       <= ov7670_data;
         phase_q      <= phase_d;
         hi_q         <= hi_d;
         x_q          <= x_d;
         y_q          <= y_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         line_err_q   <= line_err_d;
`ifndef CAPTURE_DOWNSCALE_EN
         addr_q       <= addr_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      hi_d         = hi_q;
      x_d          = x_q;
      y_d          = y_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      line_err_d   = line_err_q;
`ifndef CAPTURE_DOWNSCALE_EN
      addr_d       = addr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (vs_rise) state_d = StSync;
         end
         StSync: begin
            if (vs_fall) begin
               state_d = StActive;
               phase_d = 1'b0;
               x_d     = '0;
               y_d     = '0;
`ifndef CAPTURE_DOWNSCALE_EN
               addr_d  = '0;
`endif
            end
         end
         StActive: begin
            // vsync wins over any simultaneous href edge or byte: the line is abandoned.
            if (vs_rise) begin
               state_d      = StSync;
               frame_done_d = 1'b1;
               phase_d      = 1'b0;
            end else if (href_fall) begin
               phase_d = 1'b0;
               if (x_q != XW'(H_ACTIVE)) line_err_d = 1'b1;
               x_d = '0;
               if (y_q != YW'(V_ACTIVE)) y_d = y_q + YW'(1);
            end else if (href_q) begin
               if (!phase_q) begin
                  phase_d = 1'b1;
                  hi_d    = {data_q[7:5], data_q[2:0]};
               end else begin
                  phase_d = 1'b0;
                  // Saturate one past H_ACTIVE so overlong lines still flag line_err.
                  if (x_q != XW'(H_ACTIVE + 1)) x_d = x_q + XW'(1);
                  if (write_ok) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = pix_addr[ADDR_W-1:0];
                     wr_data_d = {hi_q, data_q[4:3]};
`ifndef CAPTURE_DOWNSCALE_EN
                     addr_d    = addr_q + CW'(1);
`endif
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign line_err   = line_err_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a reduced 8x4 frame: table vectors, hand sequences, random frames
// scored against a pixel-level reference model.

module tb_ov7670_capture;

   localparam int H = 8;
   localparam int V = 4;
   localparam int AW = 5;
`ifdef CAPTURE_DOWNSCALE_EN
   localparam int LIMIT = (H * V) / 4;
`else
   localparam int LIMIT = H * V;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vsync = 1'b0;
   logic          href = 1'b0;
   logic [7:0]    data = 8'h00;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          frame_done;
   logic          line_err;

   ov7670_capture #(
      .H_ACTIVE(H),
      .V_ACTIVE(V),
      .ADDR_W  (AW)
   ) dut (
      .ov7670_pclk (clk),
      .reset       (rst),
      .ov7670_vsync(vsync),
      .ov7670_href (href),
      .ov7670_data (data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_done  (frame_done),
      .line_err    (line_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] exp;
   } vec_t;

   wr_t        got_q[$];
   wr_t        exp_q[$];
   logic [7:0] feed_q[$];
   vec_t       tbl[8];
   int         fd_cnt = 0;
   int         consec_cnt = 0;
   logic       prev_en = 1'b0;
   int         n_vec = 0;
   int         n_err = 0;
   int         m_line = 0, m_bytes = 0, m_n = 0;
   logic [7:0] m_hi = 8'h00;
   logic       m_err = 1'b0;
   int         got_base = 0, fd_base = 0;

   always @(negedge clk) begin
      wr_t w;
      if (!rst) begin
         if (wr_en) begin
            w.addr = wr_addr;
            w.data = wr_data;
            got_q.push_back(w);
         end
         if (wr_en && prev_en) consec_cnt++;
         if (frame_done) fd_cnt++;
      end
      prev_en = wr_en && !rst;
   end

   function automatic void chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endfunction

   // RGB565 split across two bytes, reduced to the top bits of each channel.
   function automatic logic [7:0] rgb332(input logic [7:0] b0, input logic [7:0] b1);
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      r = b0[7:3];
      g = {b0[2:0], b1[7:5]};
      b = b1[4:0];
      return {r[4:2], g[5:3], b[4:3]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_pixel(input int x, input logic [7:0] d);
      wr_t w;
      w.data = d;
`ifdef CAPTURE_DOWNSCALE_EN
      if ((x % 2 == 0) && (m_line % 2 == 0) && (x < H) && (m_line < V)) begin
         w.addr = AW'((m_line / 2) * (H / 2) + x / 2);
         exp_q.push_back(w);
      end
`else
      if ((m_line < V) && (m_n < LIMIT)) begin
         w.addr = AW'(m_n);
         exp_q.push_back(w);
         m_n++;
      end
`endif
   endtask

   task automatic drive_byte(input logic [7:0] b);
      href = 1'b1;
      data = b;
      if (m_bytes % 2 == 0) m_hi = b;
      else model_pixel((m_bytes - 1) / 2, rgb332(m_hi, b));
      m_bytes++;
      step();
   endtask

   task automatic end_line(input int gap);
      href = 1'b0;
      if (m_bytes / 2 != H) m_err = 1'b1;
      m_line++;
      m_bytes = 0;
      repeat (gap) step();
   endtask

   task automatic send_line(input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         if (feed_q.size() > 0) drive_byte(feed_q.pop_front());
         else drive_byte(8'($urandom));
      end
      end_line(int'($urandom_range(1, 4)));
   endtask

   // href activity the DUT must ignore; no model bookkeeping.
   task automatic raw_bytes(input int n);
      for (int i = 0; i < n; i++) begin
         href = 1'b1;
         data = 8'($urandom);
         step();
      end
      href = 1'b0;
   endtask

   task automatic begin_frame();
      vsync = 1'b1;
      href  = 1'b0;
      repeat (2) step();
      raw_bytes(4);
      repeat (2) step();
      vsync = 1'b0;
      repeat (3) step();
      m_line  = 0;
      m_bytes = 0;
      m_n     = 0;
      exp_q.delete();
      got_base = got_q.size();
      fd_base  = fd_cnt;
   endtask

   task automatic end_frame(input string tag);
      int n;
      vsync = 1'b1;
      href  = 1'b0;
      repeat (4) step();
      chk({tag, "_wr_count"}, got_q.size() - got_base, exp_q.size());
      n = exp_q.size();
      if (got_q.size() - got_base < n) n = got_q.size() - got_base;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_addr"}, int'(got_q[got_base + i].addr), int'(exp_q[i].addr));
         chk({tag, "_data"}, int'(got_q[got_base + i].data), int'(exp_q[i].data));
      end
      chk({tag, "_frame_done"}, fd_cnt - fd_base, 1);
      chk({tag, "_line_err"}, int'(line_err), int'(m_err));
      chk({tag, "_wr_spacing"}, consec_cnt, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_wr_addr"}, int'(wr_addr), 0);
      chk({tag, "_wr_data"}, int'(wr_data), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_line_err"}, int'(line_err), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      tbl[0] = '{8'hF8, 8'h00, 8'hE0};
      tbl[1] = '{8'h07, 8'hE0, 8'h1C};
      tbl[2] = '{8'h00, 8'h1F, 8'h03};
      tbl[3] = '{8'hFF, 8'hFF, 8'hFF};
      tbl[4] = '{8'h00, 8'h00, 8'h00};
      tbl[5] = '{8'hA5, 8'h5A, 8'hB7};
      tbl[6] = '{8'h12, 8'h34, 8'h0A};
      tbl[7] = '{8'h84, 8'h10, 8'h92};

      // Reset values
      #2 rst = 1'b1;
      #1 check_reset_outputs("reset");
      repeat (3) step();
      rst = 1'b0;
      step();

      // href activity in IDLE is ignored
      raw_bytes(2 * H);
      repeat (4) step();
      chk("idle_ignored", got_q.size(), 0);

      // Table-driven line followed by random full lines
      begin_frame();
      for (int i = 0; i < 8; i++) begin
         feed_q.push_back(tbl[i].b0);
         feed_q.push_back(tbl[i].b1);
      end
      for (int l = 0; l < V; l++) send_line(2 * H);
      end_frame("table");
`ifndef CAPTURE_DOWNSCALE_EN
      for (int i = 0; i < 8; i++) begin
         chk("tbl_present", int'(got_q.size() > got_base + i), 1);
         if (got_q.size() > got_base + i)
            chk("tbl_data", int'(got_q[got_base + i].data), int'(tbl[i].exp));
      end
`endif

      // Write latency: one pclk after the second byte is registered
      begin_frame();
      drive_byte(8'h07);
      drive_byte(8'hE0);
      chk("lat_early", int'(wr_en), 0);
      drive_byte(8'h00);
      chk("lat_green_en", int'(wr_en), 1);
      chk("lat_green_data", int'(wr_data), 8'h1C);
      drive_byte(8'h1F);
      chk("lat_gap", int'(wr_en), 0);
      drive_byte(8'($urandom));
`ifndef CAPTURE_DOWNSCALE_EN
      chk("lat_blue_en", int'(wr_en), 1);
      chk("lat_blue_data", int'(wr_data), 8'h03);
`endif
      for (int i = 5; i < 2 * H; i++) drive_byte(8'($urandom));
      end_line(2);
      for (int l = 1; l < V; l++) send_line(2 * H);
      end_frame("latency");

      // Extra line: writes stop at the bound, no wrap
      begin_frame();
      for (int l = 0; l <= V; l++) send_line(2 * H);
      end_frame("overflow");
      chk("ovf_any", int'(got_q.size() > got_base), 1);
      if (got_q.size() > got_base)
         chk("ovf_last_addr", int'(got_q[got_q.size() - 1].addr), LIMIT - 1);

      // vsync rises mid-line: frame_done pulses, no line check
      begin_frame();
      send_line(2 * H);
      send_line(2 * H);
      for (int i = 0; i < 6; i++) drive_byte(8'($urandom));
      vsync = 1'b1;
      data  = 8'($urandom);
      step();
      href = 1'b0;
      step();
      end_frame("vs_abort");

      // Odd short line, then overlong line: line_err sets and stays set
      begin_frame();
      send_line(2 * H - 1);
      send_line(2 * H + 4);
      send_line(2 * H);
      send_line(2 * H);
      end_frame("short_line");
      begin_frame();
      for (int l = 0; l < V; l++) send_line(2 * H);
      end_frame("sticky");

      // Reset in the middle of an active line
      begin_frame();
      for (int i = 0; i < 5; i++) drive_byte(8'($urandom));
      rst = 1'b1;
      step();
      check_reset_outputs("mid_reset");
      raw_bytes(2);
      step();
      rst = 1'b0;
      m_err = 1'b0;
      base = got_q.size();
      raw_bytes(2 * H);
      repeat (3) step();
      raw_bytes(2 * H);
      repeat (3) step();
      chk("post_reset_quiet", got_q.size() - base, 0);
      begin_frame();
      for (int l = 0; l < V; l++) send_line(2 * H);
      end_frame("after_reset");

      // Random frames with occasional bad line lengths and extra lines
      for (int f = 0; f < 4; f++) begin
         int nl;
         begin_frame();
         nl = int'($urandom_range(V - 1, V + 1));
         for (int l = 0; l < nl; l++) begin
            if ($urandom_range(0, 3) == 0) send_line(int'($urandom_range(2 * H - 3, 2 * H + 3)));
            else send_line(2 * H);
         end
         end_frame("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
